pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Turns single-cycle request strobes into clean, fixed-width output pulses separated by a guaranteed low gap. It is the driving end of the 4-stage hold-filter path: the output is wide enough to pass a downstream filter that needs 4 consecutive high samples. Requests that arrive while a pulse is in flight are counted and replayed in order. Requests beyond capacity are dropped and flagged.

## Interface
- HOLD_CYCLES, 6: cycles `pulse_out` stays high per request; must be ≥ 4.
- GAP_CYCLES, 2: minimum low cycles between consecutive pulses; must be ≥ 1.
- PEND_MAX, 3: maximum queued requests; must be ≥ 1.
- clk  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- trigger  input  1  request strobe, sampled each rising edge; every high sample is one request (level, not edge detected).
- pulse_out  output  1  stretched pulse, registered.
- busy  output  1  high whenever state ≠ IDLE, registered.
- pending  output  clog2(PEND_MAX+1)  queued request count, registered.
- overflow  output  1  one-cycle flag: a request was dropped on the previous edge.

## Operation
- States: IDLE, HOLD, GAP. A cycle counter counts down within HOLD and GAP.
- Reset, asserted at any time including mid-pulse:
  - takes effect immediately, without waiting for a clock edge;
  - state goes to IDLE; counter, `pending`, `pulse_out`, `busy` and `overflow` all go to 0;
  - queued requests are discarded.
- IDLE:
  - trigger=1 → HOLD, counter loads HOLD_CYCLES-1, `pulse_out` goes to 1.
  - trigger=0 → stay in IDLE.
- HOLD:
  - Counter decrements each edge.
  - At counter=0 → GAP, counter loads GAP_CYCLES-1, `pulse_out` goes to 0.
- GAP:
  - Counter decrements each edge.
  - At counter=0, let eff = pending + trigger.
  - eff > 0 → HOLD, `pulse_out` goes to 1, pending becomes eff-1.
  - eff = 0 → IDLE.
- trigger in HOLD, or in GAP before its last cycle:
  - pending < PEND_MAX → pending+1.
  - pending = PEND_MAX → pending unchanged, `overflow` goes to 1 for one cycle.
- trigger on the GAP exit edge is consumed directly by the eff rule. It never sets `overflow`, even when pending = PEND_MAX.
- `pending` saturates and never wraps. `overflow` deasserts on the next edge unless another request is dropped.

## Timing
- Latency: trigger sampled at edge k → `pulse_out` high on cycles k+1 … k+HOLD_CYCLES.
- The pulse is exactly HOLD_CYCLES wide; the gap is exactly GAP_CYCLES wide, even when back-to-back requests are queued.
- Back-to-back period is HOLD_CYCLES+GAP_CYCLES cycles.
- `busy` covers all HOLD and GAP cycles and drops on the first IDLE cycle.
- Every output is a flop output; there are no combinational paths from `trigger` to any output.

## Structure
- Shared package/include holds:
  - state encoding constants ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2;
  - minimum hold constant FILTER_DEPTH=4, used to check that HOLD_CYCLES ≥ FILTER_DEPTH at elaboration.
- One natural sub-module, `pend_counter`: a saturating up/down counter with inc, dec and sat outputs. It owns the simultaneous inc/dec rule (net unchanged) and generates `overflow`.
- The FSM and the cycle down-counter live in the top module.

## Test plan
All scenarios use the defaults (HOLD_CYCLES=6, GAP_CYCLES=2, PEND_MAX=3). Cycle numbers are the cycle in which the value is visible.
- Single trigger at cycle 10 → `pulse_out` high 11–16, low 17–18; `busy` high 11–18; IDLE at 19; `pending` 0 throughout.
- Triggers at 10 and 13 → `pending`=1 during 14–18; second pulse 19–24; `busy` stays high 11–26.
- Trigger held high 10–15:
  - `pending` steps 1, 2, 3 on cycles 12, 13, 14;
  - `overflow` high on 15 and 16;
  - four pulses total, starting at 11, 19, 27 and 35.
- Trigger only on cycle 18 (last GAP cycle, pending=0) → next pulse 19–24; `pending` stays 0; no `overflow`.
- reset_n low at cycle 13 mid-pulse with `pending`=2:
  - `pulse_out`, `busy` and `pending` go to 0 immediately, without a clock edge;
  - after release, trigger at cycle 30 gives a pulse on 31–36 only, with no replay of the discarded requests.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// ============================================================================
// Module   : pulse_stretcher_pkg
// Brief    : Shared state encoding and sizing helpers for pulse_stretcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_stretcher_pkg;

    // Downstream hold filter needs this many consecutive high samples.
    localparam int FILTER_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int cnt_width(input int hold, input int gap);
        int max_val;
        max_val = (hold > gap) ? hold : gap;
        return (max_val > 2) ? $clog2(max_val) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretcher_pend_counter.sv
// ============================================================================
// Module   : pend_counter
// Brief    : Saturating up/down request counter with drop (overflow) flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pend_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_sat,
    output logic         o_overflow
);

    localparam logic [W-1:0] c_MAX = W'(MAX);
    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_count;
    logic         r_overflow;
    logic         w_sat;

    assign w_sat = (r_count == c_MAX);

    // A simultaneous inc and dec is a request replayed in the same edge it
    // arrived: net count unchanged and nothing is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_inc && !i_dec && w_sat;
            case ({i_inc, i_dec})
                2'b10: if (!w_sat)         r_count <= r_count + c_ONE;
                2'b01: if (r_count != '0)  r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_sat      = w_sat;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// Module   : pulse_stretcher
// Brief    : Stretches request strobes into fixed-width pulses with a
//            guaranteed low gap, queueing and replaying overlapping requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          trigger,
    output logic                          pulse_out,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pending,
    output logic                          overflow
);

    localparam int c_CNT_W  = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int c_PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PEND_W-1:0] c_PEND_MAX  = c_PEND_W'(PEND_MAX);

    if (HOLD_CYCLES < FILTER_DEPTH) begin : g_chk_hold
        $error("HOLD_CYCLES must be at least FILTER_DEPTH");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("GAP_CYCLES must be at least 1");
    end
    if (PEND_MAX < 1) begin : g_chk_pend
        $error("PEND_MAX must be at least 1");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_pulse;
    logic               r_busy;
    logic               w_gap_exit;
    logic               w_eff_nz;
    logic               w_inc;
    logic               w_dec;
    logic               w_pend_sat;

    assign w_gap_exit = (r_state == ST_GAP) && (r_cnt == '0);
    assign w_eff_nz   = (pending != '0) || trigger;

    // Every request seen outside IDLE is queued; on the gap exit edge a
    // same-edge request cancels against the replay inside pend_counter.
    assign w_inc = trigger && (r_state != ST_IDLE);
    assign w_dec = w_gap_exit && w_eff_nz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= (w_state_nxt == ST_HOLD);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (trigger) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    if (w_eff_nz) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = c_HOLD_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    pend_counter #(
        .MAX (PEND_MAX),
        .W   (c_PEND_W)
    ) u_pend_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .o_count    (pending),
        .o_sat      (w_pend_sat),
        .o_overflow (overflow)
    );

    a_sat_consistent: assert property (@(posedge clk) disable iff (!reset_n)
        w_pend_sat == (pending == c_PEND_MAX));

    assign pulse_out = r_pulse;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// Module   : tb_pulse_stretcher
// Brief    : Directed self-checking bench for pulse_stretcher (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       trigger = 1'b0;
    logic       pulse_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .HOLD_CYCLES (6),
        .GAP_CYCLES  (2),
        .PEND_MAX    (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trigger   (trigger),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input bit ep, input bit eb,
                               input int epend, input bit eo);
        check_value({tag, "_pulse"},    32'(pulse_out), 32'(ep));
        check_value({tag, "_busy"},     32'(busy),      32'(eb));
        check_value({tag, "_pending"},  32'(pending),   epend);
        check_value({tag, "_overflow"}, 32'(overflow),  32'(eo));
    endtask

    // Cycle n starts at rising edge n; outputs are sampled 1 time unit later
    // and trigger for cycle n is driven right after that sample.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        trigger = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_cycle("rst", 1'b0, 1'b0, 0, 1'b0);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #2;

        // Single request
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            tick();
            check_cycle("single", cyc >= 11 && cyc <= 16,
                        cyc >= 11 && cyc <= 18, 0, 1'b0);
            trigger = (cyc == 10);
        end

        // Second request during HOLD is queued and replayed
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            check_cycle("queue1",
                        (cyc >= 11 && cyc <= 16) || (cyc >= 19 && cyc <= 24),
                        cyc >= 11 && cyc <= 26,
                        (cyc >= 14 && cyc <= 18) ? 1 : 0, 1'b0);
            trigger = (cyc == 10) || (cyc == 13);
        end

        // Trigger held six cycles: saturation and two drops
        apply_reset();
        for (int i = 0; i < 46; i++) begin
            tick();
            check_cycle("held",
                        cyc >= 11 && cyc <= 40 && ((cyc - 11) % 8) < 6,
                        cyc >= 11 && cyc <= 42,
                        (cyc == 12) ? 1 :
                        (cyc == 13) ? 2 :
                        (cyc >= 14 && cyc <= 18) ? 3 :
                        (cyc >= 19 && cyc <= 26) ? 2 :
                        (cyc >= 27 && cyc <= 34) ? 1 : 0,
                        cyc == 15 || cyc == 16);
            trigger = (cyc >= 10 && cyc <= 15);
        end

        // Request on last GAP cycle with nothing queued
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            check_cycle("gapexit",
                        (cyc >= 11 && cyc <= 16) || (cyc >= 19 && cyc <= 24),
                        cyc >= 11 && cyc <= 26, 0, 1'b0);
            trigger = (cyc == 10) || (cyc == 18);
        end

        // Request on gap exit edge while saturated: consumed, no drop
        apply_reset();
        for (int i = 0; i < 54; i++) begin
            tick();
            check_cycle("satexit",
                        cyc >= 11 && cyc <= 48 && ((cyc - 11) % 8) < 6,
                        cyc >= 11 && cyc <= 50,
                        (cyc == 12) ? 1 :
                        (cyc == 13) ? 2 :
                        (cyc >= 14 && cyc <= 26) ? 3 :
                        (cyc >= 27 && cyc <= 34) ? 2 :
                        (cyc >= 35 && cyc <= 42) ? 1 : 0,
                        1'b0);
            trigger = (cyc >= 10 && cyc <= 13) || (cyc == 18);
        end

        // Asynchronous reset mid-pulse discards the queue
        apply_reset();
        for (int i = 0; i < 45; i++) begin
            tick();
            check_cycle("areset",
                        (cyc >= 11 && cyc <= 13) || (cyc >= 31 && cyc <= 36),
                        (cyc >= 11 && cyc <= 13) || (cyc >= 31 && cyc <= 38),
                        (cyc == 12) ? 1 : (cyc == 13) ? 2 : 0, 1'b0);
            trigger = (cyc >= 10 && cyc <= 12) || (cyc == 30);
            if (cyc == 13) begin
                trigger = 1'b0;
                #2;
                reset_n = 1'b0;
                #1;
                check_cycle("areset_now", 1'b0, 1'b0, 0, 1'b0);
            end
            if (cyc == 20) reset_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
